// File: rtl/snes_pkg.sv
// Shared definitions for the multi-pad SNES controller reader:
// button indices, FSM encoding and default timing.
package snes_pkg;

    localparam int unsigned BTN_B      = 0;
    localparam int unsigned BTN_Y      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;
    localparam int unsigned BTN_A      = 8;
    localparam int unsigned BTN_X      = 9;
    localparam int unsigned BTN_L      = 10;
    localparam int unsigned BTN_R      = 11;

    localparam int unsigned DEF_CLK_HZ            = 100_000_000;
    localparam int unsigned DEF_POLL_HZ           = 60;
    localparam int unsigned DEF_BIT_PERIOD_CYCLES = 1200;
    localparam int unsigned DEF_NUM_PADS          = 2;
    localparam int unsigned DEF_BUTTON_COUNT      = 12;
    localparam int unsigned DEF_FRAME_BITS        = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LATCH  = 2'd1,
        SHIFT  = 2'd2,
        COMMIT = 2'd3
    } snes_state_e;

endpackage

// File: rtl/snes_multi_controller_if.sv
// Pad-side serial lines plus the published button/event/presence bus.
interface snes_multi_controller_if
    import snes_pkg::*;
#(
    parameter int unsigned NUM_PADS     = DEF_NUM_PADS,
    parameter int unsigned BUTTON_COUNT = DEF_BUTTON_COUNT
);

    logic [NUM_PADS-1:0]              serial_in;
    logic                             poll_start;
    logic                             data_clk;
    logic                             data_latch;
    logic [NUM_PADS*BUTTON_COUNT-1:0] button_state;
    logic [NUM_PADS*BUTTON_COUNT-1:0] pressed;
    logic [NUM_PADS*BUTTON_COUNT-1:0] released;
    logic [NUM_PADS-1:0]              present;
    logic                             sample_valid;
    logic                             busy;

    // master: the controller reader; slave: pads and consumers
    modport master (
        input  serial_in, poll_start,
        output data_clk, data_latch, button_state, pressed, released,
               present, sample_valid, busy
    );

    modport slave (
        output serial_in, poll_start,
        input  data_clk, data_latch, button_state, pressed, released,
               present, sample_valid, busy
    );

endinterface

// File: rtl/snes_pad_shifter.sv
// One pad's serial capture: button buffer, presence check, committed state
// and one-cycle press/release edge masks.
module snes_pad_shifter
    import snes_pkg::*;
#(
    parameter int unsigned BUTTON_COUNT = DEF_BUTTON_COUNT,
    parameter int unsigned FRAME_BITS   = DEF_FRAME_BITS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          serial_bit,
    input  logic                          sample_en,
    input  logic [$clog2(FRAME_BITS)-1:0] bit_index,
    input  logic                          commit,
    output logic [BUTTON_COUNT-1:0]       button_state,
    output logic [BUTTON_COUNT-1:0]       pressed,
    output logic [BUTTON_COUNT-1:0]       released,
    output logic                          present
);

    localparam int unsigned BIT_W = $clog2(FRAME_BITS);

    logic [BUTTON_COUNT-1:0] shift_buf;
    logic                    pres_acc;
    logic [BUTTON_COUNT-1:0] new_state_c;

    // an absent pad reports no buttons, which turns held ones into releases
    assign new_state_c = pres_acc ? shift_buf : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_buf    <= '0;
            pres_acc     <= 1'b0;
            button_state <= '0;
            pressed      <= '0;
            released     <= '0;
            present      <= 1'b0;
        end else begin
            pressed  <= '0;
            released <= '0;
            if (sample_en) begin
                for (int unsigned i = 0; i < BUTTON_COUNT; i++) begin
                    if (bit_index == BIT_W'(i)) begin
                        shift_buf[i] <= ~serial_bit;
                    end
                end
                // trailing bits must all read high for a real pad
                if (bit_index == BIT_W'(BUTTON_COUNT)) begin
                    pres_acc <= serial_bit;
                end else if (bit_index > BIT_W'(BUTTON_COUNT)) begin
                    pres_acc <= pres_acc & serial_bit;
                end
            end
            if (commit) begin
                button_state <= new_state_c;
                pressed      <= new_state_c & ~button_state;
                released     <= button_state & ~new_state_c;
                present      <= pres_acc;
            end
        end
    end

endmodule

// File: rtl/snes_multi_controller.sv
// Polls NUM_PADS SNES pads over a shared latch/clock pair and publishes
// per-pad button state, edge masks and presence.
module snes_multi_controller
    import snes_pkg::*;
#(
    parameter int unsigned CLK_HZ            = DEF_CLK_HZ,
    parameter int unsigned POLL_HZ           = DEF_POLL_HZ,
    parameter int unsigned BIT_PERIOD_CYCLES = DEF_BIT_PERIOD_CYCLES,
    parameter int unsigned NUM_PADS          = DEF_NUM_PADS,
    parameter int unsigned BUTTON_COUNT      = DEF_BUTTON_COUNT,
    parameter int unsigned FRAME_BITS        = DEF_FRAME_BITS,
    parameter int unsigned AUTO_POLL         = 1
) (
    input logic                      clk,
    input logic                      rst,
    snes_multi_controller_if.master  bus
);

    localparam int unsigned TICK_CYCLES = CLK_HZ / POLL_HZ;
    localparam int unsigned TICK_W      = $clog2(TICK_CYCLES + 1);
    localparam int unsigned PH_W        = $clog2(BIT_PERIOD_CYCLES);
    localparam int unsigned HALF        = BIT_PERIOD_CYCLES / 2;
    localparam int unsigned BIT_W       = $clog2(FRAME_BITS);
    localparam int unsigned LANES       = NUM_PADS * BUTTON_COUNT;

    snes_state_e       state, state_n;
    logic [PH_W-1:0]   phase, phase_n;
    logic [BIT_W-1:0]  bit_idx, bit_n;
    logic [TICK_W-1:0] tick_cnt;

    logic data_clk_q, data_latch_q, busy_q, sample_valid_q;
    logic data_clk_n, data_latch_n, busy_n;
    logic tick_c, start_c, phase_last_c, sample_en_c, commit_c;

    logic [LANES-1:0]    state_w, pressed_w, released_w;
    logic [NUM_PADS-1:0] present_w;

    assign tick_c       = (tick_cnt == '0);
    assign start_c      = (AUTO_POLL != 0) ? tick_c : bus.poll_start;
    assign phase_last_c = (phase == PH_W'(BIT_PERIOD_CYCLES - 1));

    // state register, counters and registered pad-side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            phase          <= '0;
            bit_idx        <= '0;
            tick_cnt       <= '0;
            data_clk_q     <= 1'b1;
            data_latch_q   <= 1'b0;
            busy_q         <= 1'b0;
            sample_valid_q <= 1'b0;
        end else begin
            state          <= state_n;
            phase          <= phase_n;
            bit_idx        <= bit_n;
            tick_cnt       <= (tick_cnt == TICK_W'(TICK_CYCLES - 1)) ? '0
                                                                     : tick_cnt + TICK_W'(1);
            data_clk_q     <= data_clk_n;
            data_latch_q   <= data_latch_n;
            busy_q         <= busy_n;
            sample_valid_q <= commit_c;
        end
    end

    // next-state and output decode; starts while busy are simply ignored
    always_comb begin
        state_n      = state;
        phase_n      = phase;
        bit_n        = bit_idx;
        sample_en_c  = 1'b0;
        commit_c     = 1'b0;
        data_clk_n   = 1'b1;
        data_latch_n = 1'b0;
        busy_n       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start_c) begin
                    state_n = LATCH;
                    phase_n = '0;
                    bit_n   = '0;
                end
            end
            LATCH: begin
                data_latch_n = 1'b1;
                if (phase_last_c) begin
                    state_n = SHIFT;
                    phase_n = '0;
                end else begin
                    phase_n = phase + PH_W'(1);
                end
            end
            SHIFT: begin
                data_clk_n  = (phase >= PH_W'(HALF));
                sample_en_c = (phase == PH_W'(HALF - 1));
                if (phase_last_c) begin
                    phase_n = '0;
                    if (bit_idx == BIT_W'(FRAME_BITS - 1)) begin
                        state_n = COMMIT;
                    end else begin
                        bit_n = bit_idx + BIT_W'(1);
                    end
                end else begin
                    phase_n = phase + PH_W'(1);
                end
            end
            COMMIT: begin
                commit_c = 1'b1;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        snes_pad_shifter #(
            .BUTTON_COUNT (BUTTON_COUNT),
            .FRAME_BITS   (FRAME_BITS)
        ) u_pad (
            .clk          (clk),
            .rst          (rst),
            .serial_bit   (bus.serial_in[p]),
            .sample_en    (sample_en_c),
            .bit_index    (bit_idx),
            .commit       (commit_c),
            .button_state (state_w[p*BUTTON_COUNT +: BUTTON_COUNT]),
            .pressed      (pressed_w[p*BUTTON_COUNT +: BUTTON_COUNT]),
            .released     (released_w[p*BUTTON_COUNT +: BUTTON_COUNT]),
            .present      (present_w[p])
        );
    end

    assign bus.data_clk     = data_clk_q;
    assign bus.data_latch   = data_latch_q;
    assign bus.busy         = busy_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.button_state = state_w;
    assign bus.pressed      = pressed_w;
    assign bus.released     = released_w;
    assign bus.present      = present_w;

endmodule

// File: tb/tb_snes_multi_controller.sv
// Directed bench: auto-poll reader with modelled pads, plus an on-demand reader.
module tb_snes_multi_controller;

    logic clk;
    logic rst_a, rst_m, poll_m;

    snes_multi_controller_if #(.NUM_PADS(2), .BUTTON_COUNT(12)) bus_a ();
    snes_multi_controller_if #(.NUM_PADS(2), .BUTTON_COUNT(12)) bus_m ();

    snes_multi_controller #(
        .CLK_HZ(12000), .POLL_HZ(60), .BIT_PERIOD_CYCLES(8), .NUM_PADS(2),
        .BUTTON_COUNT(12), .FRAME_BITS(16), .AUTO_POLL(1)
    ) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));

    snes_multi_controller #(
        .CLK_HZ(12000), .POLL_HZ(60), .BIT_PERIOD_CYCLES(8), .NUM_PADS(2),
        .BUTTON_COUNT(12), .FRAME_BITS(16), .AUTO_POLL(0)
    ) dut_m (.clk(clk), .rst(rst_m), .bus(bus_m));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // pad model: latch reloads, each rising data_clk advances one bit
    logic [1:0]  pad_conn;
    logic [11:0] pad_btn0, pad_btn1;
    int unsigned pad_idx = 0;
    logic        clk_prev = 1'b1;

    always @(negedge clk) begin
        if (bus_a.data_latch) pad_idx <= 0;
        else if (bus_a.data_clk && !clk_prev) pad_idx <= pad_idx + 1;
        clk_prev <= bus_a.data_clk;
    end

    function automatic logic line_level(input logic conn, input logic [11:0] btn,
                                        input int unsigned idx);
        logic [15:0] frame;
        frame = {4'hF, ~btn};
        if (!conn) return 1'b0;
        if (idx >= 16) return 1'b1;
        return frame[idx[3:0]];
    endfunction

    assign bus_a.serial_in  = {line_level(pad_conn[1], pad_btn1, pad_idx),
                               line_level(pad_conn[0], pad_btn0, pad_idx)};
    assign bus_a.poll_start = 1'b0;
    assign bus_m.serial_in  = 2'b00;
    assign bus_m.poll_start = poll_m;

    // activity monitor for the on-demand reader
    int   sv_m_cnt = 0, busy_m_cnt = 0, latch_m_rises = 0;
    logic latch_m_prev = 1'b0;
    always @(negedge clk) begin
        if (bus_m.sample_valid) sv_m_cnt <= sv_m_cnt + 1;
        if (bus_m.busy) busy_m_cnt <= busy_m_cnt + 1;
        if (bus_m.data_latch && !latch_m_prev) latch_m_rises <= latch_m_rises + 1;
        latch_m_prev <= bus_m.data_latch;
    end

    typedef struct {
        logic [1:0]  conn;
        logic [11:0] b0, b1;
        logic [23:0] st, pr, rl;
        logic [1:0]  pres;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_sv(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus_a.sample_valid) begin
                seen = 1'b1;
                return;
            end
        end
    endtask

    // called on the sample_valid cycle; also checks the strobes drop next cycle
    task automatic check_frame(input vec_t v, input string tag);
        check({tag, ".state"},    32'(bus_a.button_state), 32'(v.st));
        check({tag, ".pressed"},  32'(bus_a.pressed),      32'(v.pr));
        check({tag, ".released"}, 32'(bus_a.released),     32'(v.rl));
        check({tag, ".present"},  32'(bus_a.present),      32'(v.pres));
        @(negedge clk);
        check({tag, ".strobes_clear"},
              32'({bus_a.sample_valid, |bus_a.pressed, |bus_a.released}), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        bit   seen;
        int   t_latch, len, run, pulses, badrun, busy_low, sv_at, early;
        int   sv0, busy0, lat0;

        vecs[0] = '{2'b01, 12'h008, 12'h000, 24'h000008, 24'h000000, 24'h000001, 2'b01};
        vecs[1] = '{2'b11, 12'h008, 12'h400, 24'h400008, 24'h400000, 24'h000000, 2'b11};
        vecs[2] = '{2'b01, 12'h008, 12'h400, 24'h000008, 24'h000000, 24'h400000, 2'b01};
        vecs[3] = '{2'b11, 12'hFFF, 12'h801, 24'h801FFF, 24'h801FF7, 24'h000000, 2'b11};
        vecs[4] = '{2'b10, 12'hFFF, 12'h001, 24'h001000, 24'h000000, 24'h800FFF, 2'b10};
        vecs[5] = '{2'b11, 12'h000, 12'h001, 24'h001000, 24'h000000, 24'h000000, 2'b11};

        rst_a = 1'b1; rst_m = 1'b1; poll_m = 1'b0;
        pad_conn = 2'b01; pad_btn0 = 12'h009; pad_btn1 = 12'h000;
        repeat (3) @(negedge clk);
        check("rst.data_clk",     32'(bus_a.data_clk),     32'd1);
        check("rst.data_latch",   32'(bus_a.data_latch),   32'd0);
        check("rst.busy",         32'(bus_a.busy),         32'd0);
        check("rst.sample_valid", 32'(bus_a.sample_valid), 32'd0);
        check("rst.outs", 32'({|bus_a.button_state, |bus_a.pressed, |bus_a.released,
                               |bus_a.present}), 32'd0);
        rst_a = 1'b0; rst_m = 1'b0;

        // first frame: latch width, clock pulses, commit latency
        t_latch = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus_a.data_latch) begin
                t_latch = cyc;
                break;
            end
        end
        check("latch.seen", 32'(t_latch >= 0), 32'd1);
        len = 0;
        while (bus_a.data_latch && len < 50) begin
            len++;
            @(negedge clk);
        end
        check("latch.len", 32'(len), 32'd8);
        run = 0; pulses = 0; badrun = 0; busy_low = 0; sv_at = -1;
        for (int i = 0; i < 300; i++) begin
            if (!bus_a.data_clk) run++;
            else if (run > 0) begin
                pulses++;
                if (run != 4) badrun++;
                run = 0;
            end
            if (!bus_a.busy) busy_low++;
            if (bus_a.sample_valid) begin
                sv_at = cyc - t_latch;
                break;
            end
            @(negedge clk);
        end
        check("clk.pulses",   32'(pulses),   32'd16);
        check("clk.bad_runs", 32'(badrun),   32'd0);
        check("frame.busy",   32'(busy_low), 32'd0);
        check("frame.sv_lat", 32'(sv_at),    32'd136);
        v = '{2'b01, 12'h009, 12'h000, 24'h000009, 24'h000009, 24'h000000, 2'b01};
        check_frame(v, "f0");

        for (int i = 0; i < 6; i++) begin
            pad_conn = vecs[i].conn;
            pad_btn0 = vecs[i].b0;
            pad_btn1 = vecs[i].b1;
            wait_sv(400, seen);
            check($sformatf("v%0d.seen", i + 1), 32'(seen), 32'd1);
            if (seen) check_frame(vecs[i], $sformatf("v%0d", i + 1));
        end

        // reset during bit 7 aborts the frame
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus_a.data_latch) begin
                seen = 1'b1;
                break;
            end
        end
        check("abort.latch_seen", 32'(seen), 32'd1);
        repeat (8 + 7 * 8 + 2) @(negedge clk);
        rst_a = 1'b1;
        repeat (2) @(negedge clk);
        check("abort.data_clk", 32'(bus_a.data_clk),   32'd1);
        check("abort.latch",    32'(bus_a.data_latch), 32'd0);
        check("abort.busy",     32'(bus_a.busy),       32'd0);
        check("abort.state",    32'(bus_a.button_state), 32'd0);
        check("abort.present",  32'(bus_a.present),    32'd0);
        rst_a = 1'b0;
        early = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (bus_a.sample_valid) early++;
        end
        check("abort.no_early_sv", 32'(early), 32'd0);
        wait_sv(200, seen);
        check("abort.next_seen", 32'(seen), 32'd1);
        v = '{2'b11, 12'h000, 12'h001, 24'h001000, 24'h001000, 24'h000000, 2'b11};
        if (seen) check_frame(v, "after_abort");

        // on-demand reader: second request while busy is dropped
        check("man.idle_no_sv", 32'(sv_m_cnt), 32'd0);
        check("man.idle_busy",  32'(bus_m.busy), 32'd0);
        sv0 = sv_m_cnt; busy0 = busy_m_cnt; lat0 = latch_m_rises;
        poll_m = 1'b1;
        @(negedge clk);
        poll_m = 1'b0;
        repeat (19) @(negedge clk);
        poll_m = 1'b1;
        @(negedge clk);
        poll_m = 1'b0;
        repeat (400) @(negedge clk);
        check("man.sv_count",    32'(sv_m_cnt - sv0),        32'd1);
        check("man.latch_count", 32'(latch_m_rises - lat0),  32'd1);
        check("man.busy_cycles", 32'(busy_m_cnt - busy0),    32'd137);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snes_multi_controller.md
Name: snes_multi_controller

Overview:
- Parametrised successor to the single-pad SNES reader.
- Polls NUM_PADS controllers over one shared latch/clock pair, each pad with its own serial data line.
- Publishes per-pad button state, one-cycle press/release event masks and a per-pad presence flag.
- Polls either on a free-running POLL_HZ tick or on demand, for the CPU I/O block and input-remapping logic.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- POLL_HZ, 60, auto-poll rate in Hz; tick period = CLK_HZ/POLL_HZ cycles.
- BIT_PERIOD_CYCLES, 1200, cycles per latch pulse and per serial bit (12 us at 100 MHz); must be even, >= 4.
- NUM_PADS, 2, number of controller ports (1..4).
- BUTTON_COUNT, 12, buttons reported per pad.
- FRAME_BITS, 16, bits clocked per frame; must be > BUTTON_COUNT.
- AUTO_POLL, 1, 1 = poll on internal tick; 0 = poll only on poll_start.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- serial_in  in  NUM_PADS  per-pad data line, active-low button level
- poll_start  in  1  on-demand poll request, sampled only when AUTO_POLL=0
- data_clk  out  1  shared controller clock, idles high
- data_latch  out  1  shared latch pulse
- button_state  out  NUM_PADS*BUTTON_COUNT  pad p at [p*BUTTON_COUNT +: BUTTON_COUNT], 1 = pressed; bit order B,Y,SELECT,START,UP,DOWN,LEFT,RIGHT,A,X,L,R
- pressed  out  NUM_PADS*BUTTON_COUNT  one-cycle mask of 0->1 transitions
- released  out  NUM_PADS*BUTTON_COUNT  one-cycle mask of 1->0 transitions
- present  out  NUM_PADS  1 = pad detected in last frame
- sample_valid  out  1  one-cycle strobe when outputs update
- busy  out  1  high from latch start through commit

Behaviour:
- Reset values: data_clk=1, data_latch=0, button_state=0, pressed=0, released=0, present=0, sample_valid=0, busy=0. State returns to IDLE; all counters and shift registers are cleared.
- Reset mid-frame aborts the frame. There is no commit and no strobe.
- Poll tick counter: free-running 0..CLK_HZ/POLL_HZ-1. The tick fires when the counter equals 0. It keeps counting regardless of state.
- Start condition:
  - AUTO_POLL=1: tick while IDLE.
  - AUTO_POLL=0: poll_start=1 while IDLE.
  - Requests or ticks arriving while busy are dropped, not queued.
- IDLE: data_clk=1, data_latch=0, busy=0. On start, clear the bit counter and phase counter, go to LATCH. busy rises the next cycle.
- LATCH: data_latch=1 and data_clk=1 for exactly BIT_PERIOD_CYCLES cycles, then go to SHIFT.
- SHIFT, bit k = 0..FRAME_BITS-1, each BIT_PERIOD_CYCLES long:
  - data_clk low for the first half and high for the second half.
  - Sample every serial_in on the last cycle of the low half (phase = BIT_PERIOD_CYCLES/2-1), just before the rising edge.
  - Bits k < BUTTON_COUNT shift into that pad's button buffer as ~serial_in; bit 0 lands at index 0.
  - Bits k >= BUTTON_COUNT feed the presence check: the pad is present iff all these bits read serial_in=1.
  - After the last bit's period, go to COMMIT.
- data_clk and data_latch are registered outputs, glitch-free.
- COMMIT, one cycle:
  - new_state = present ? buffer : 0, per pad.
  - pressed = new & ~old; released = old & ~new.
  - button_state <= new_state; present updates; sample_valid=1. All of these are visible in the same cycle.
  - Then go to IDLE.
- pressed, released and sample_valid are 0 in every cycle except the one following COMMIT.
- Unplugged pad (line pulled low) reads not present. Its buttons are forced to 0, and a release event is emitted for buttons held before the unplug.
- Frame length = (FRAME_BITS+1)*BIT_PERIOD_CYCLES. At defaults this is 20400 cycles, well under the 1666666-cycle tick period.

Decomposition:
- Shared package snes_pkg holds:
  - button index constants (BTN_B=0 .. BTN_R=11);
  - state encoding (IDLE, LATCH, SHIFT, COMMIT);
  - default timing constants.
- Sub-module snes_pad_shifter, instantiated NUM_PADS times. It contains the per-pad shift buffer, presence check, commit register and edge detection. Its inputs are sample_en, bit_index, commit and rst.
- The top level owns the timers, the FSM, and data_clk/data_latch generation.

Test Plan:
- Sim parameters CLK_HZ=12000, POLL_HZ=60, BIT_PERIOD_CYCLES=8, NUM_PADS=2.
- Reset then idle: after rst, data_clk=1, data_latch=0, all outputs 0; first latch pulse lasts exactly 8 cycles; 16 clock low pulses of 4 cycles each follow; sample_valid fires 136 cycles after latch start.
- Pad 0 models B+START (bits 0,3 driven low), trailing bits high; pad 1 line held low -> button_state[11:0]=12'h009, pressed[11:0]=12'h009, present=2'b01, button_state[23:12]=0.
- Next frame, pad 0 releases B only -> button_state[11:0]=12'h008, released[11:0]=12'h001, pressed=0.
- AUTO_POLL=0: poll_start pulsed twice, 20 cycles apart -> exactly one frame and one sample_valid; busy high throughout the frame.
- Assert rst at bit 7 of the frame -> no sample_valid; outputs return to reset values; the next frame completes normally.
- Pad 1 connected with L held -> button_state[23:12]=12'h400 and present[1]=1; then hold the line low -> present[1]=0 and released[23:12]=12'h400.
